ram_fifo_sync: RTL

//  Parametrised single-clock FIFO built on an inferred simple-dual-port RAM; successor to the fixed
//  1024x8 RAM wrapper. Adds push/pop handshake, occupancy tracking, programmable almost-flags and

---
 rtl/ram_fifo_pkg.sv | 30 +++
 rtl/ram_fifo_mem.sv | 33 +++
 rtl/ram_fifo_sync.sv | 97 +++++++++
 3 files changed

// File: rtl/ram_fifo_pkg.sv
// Shared helpers for the RAM-backed synchronous FIFO: width derivation and
// occupancy threshold compares used by the flag logic.
package ram_fifo_pkg;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

  function automatic int ptr_w(input int depth);
    return clog2(depth);
  endfunction

  function automatic int level_w(input int depth);
    return clog2(depth) + 1;
  endfunction

  function automatic logic at_or_above(input int level, input int threshold);
    return level >= threshold;
  endfunction

  function automatic logic at_or_below(input int level, input int threshold);
    return level <= threshold;
  endfunction

endpackage

// File: rtl/ram_fifo_mem.sv
// Simple-dual-port RAM, one write and one registered read port, read-first on
// an address collision. Only the read register is reset; the array is not.
module ram_fifo_mem #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Non-blocking semantics give the old word when read and write hit the same address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/ram_fifo_sync.sv
// Single-clock FIFO over an inferred SDP RAM with occupancy, almost-flags and
// error pulses. Define RAM_FIFO_FWFT_EN for first-word-fall-through output.
module ram_fifo_sync
  import ram_fifo_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 1024,
  parameter int ADDR_W    = clog2(DEPTH),
  parameter int AF_MARGIN = 4,
  parameter int AE_MARGIN = 4
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              Push,
  input  logic [DATA_W-1:0] WD,
  input  logic              Pop,
  output logic [DATA_W-1:0] RD,
  output logic              Full,
  output logic              Empty,
  output logic              Almost_Full,
  output logic              Almost_Empty,
  output logic [ADDR_W:0]   Level,
  output logic              Overflow,
  output logic              Underflow
);

  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   level_next;
  logic              push_ok;
  logic              pop_ok;
  logic              rd_en;
  logic              empty_next;

  assign pop_ok  = Pop & ~Empty;
  assign push_ok = Push & (~Full | pop_ok);

  always_comb begin
    level_next = Level + {{ADDR_W{1'b0}}, push_ok} - {{ADDR_W{1'b0}}, pop_ok};
  end

`ifdef RAM_FIFO_FWFT_EN
  // The RAM read register is the head slot: refill it whenever it is free or being
  // consumed and the array still holds words (Level minus the head slot).
  logic vld_next;

  always_comb begin
    rd_en    = (Level != {{ADDR_W{1'b0}}, ~Empty}) & (Empty | pop_ok);
    vld_next = rd_en | (~Empty & ~pop_ok);
  end

  assign empty_next = ~vld_next;
`else
  assign rd_en      = pop_ok;
  assign empty_next = (level_next == '0);
`endif

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      Level        <= '0;
      Empty        <= 1'b1;
      Almost_Empty <= 1'b1;
      Full         <= 1'b0;
      Almost_Full  <= 1'b0;
      Overflow     <= 1'b0;
      Underflow    <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (rd_en)   rd_ptr <= rd_ptr + ADDR_W'(1);
      Level        <= level_next;
      Empty        <= empty_next;
      Full         <= at_or_above(int'(level_next), DEPTH);
      Almost_Full  <= at_or_above(int'(level_next), DEPTH - AF_MARGIN);
      Almost_Empty <= at_or_below(int'(level_next), AE_MARGIN);
      Overflow     <= Push & Full & ~pop_ok;
      Underflow    <= Pop & Empty;
    end
  end

  ram_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk     (Clk),
    .rst_n   (Rst_n),
    .wr_en   (push_ok),
    .wr_addr (wr_ptr),
    .wr_data (WD),
    .rd_en   (rd_en),
    .rd_addr (rd_ptr),
    .rd_data (RD)
  );

endmodule
